alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- Execute-to-writeback stage directly downstream of the 16-bit ALU.
- Registers the ALU result, destination register and opcode into a 2-entry skid buffer with valid/ready handshakes.
- Owns the architectural condition-code register {S,Z,C,V} and drives register-file write-back.
- Evaluates branch conditions from the held flags for the fetch/branch unit.

Parameters:
- DATA_W, 16, datapath width; must match the ALU result width.
- REG_AW, 3, register-file address width (8 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  ALU result valid this cycle.
- in_ready  out  1  stage can accept an entry; registered, equals ~skid_valid.
- alu_out  in  DATA_W  ALU result.
- alu_s, alu_z, alu_c, alu_v  in  1 each  ALU flag outputs.
- opcode  in  4  ALU opcode that produced alu_out.
- rd  in  REG_AW  destination register.
- flush  in  1  discard all buffered entries (branch taken or trap).
- out_valid  out  1  head entry valid.
- out_ready  in  1  write-back port consumes the head entry.
- wb_data  out  DATA_W  head entry result.
- wb_rd  out  REG_AW  head entry destination.
- wb_we  out  1  out_valid AND head entry is a writing opcode.
- flags_q  out  4  condition codes {S,Z,C,V}.
- cond  in  3  branch condition select.
- cond_true  out  1  selected condition holds.

Behaviour:
- Reset (rst=1 at a clk edge):
  - main_valid=0, skid_valid=0, in_ready=1 after the edge.
  - out_valid=0, wb_we=0, wb_data=0, wb_rd=0, flags_q=0.
  - Reset mid-transfer drops all entries.
- Accept condition: in_valid & in_ready & ~flush.
- Latency: an entry accepted at edge N gives out_valid=1 during cycle N+1.
- Throughput: 1 entry per cycle while out_ready=1.
- Buffer moves:
  - Main empty, or main being consumed (out_ready=1) with skid empty: accepted entry goes to main.
  - Main valid, out_ready=0: accepted entry goes to skid. in_ready falls on the next cycle.
  - Skid valid and out_ready=1: skid moves to main, skid clears, in_ready rises next cycle.
  - Both entries full with out_ready=0: hold everything; in_ready=0.
- Head order always equals acceptance order.
- Write enable by opcode:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 6 MOV: wb_we=1.
  - 5 CMP and 7..15: wb_we=0; the entry still flows through the handshake.
- Flag update, applied at acceptance (not at write-back):
  - Opcodes 0, 1, 5: S, Z, C, V loaded from the ALU.
  - Opcodes 2, 3, 4, 6: S, Z loaded; C and V cleared to 0.
  - Opcodes 7..15: flags unchanged.
- Flush:
  - Clears main_valid and skid_valid at the edge.
  - An entry presented in the same cycle is not accepted and does not touch flags.
  - flags_q retains its value.
  - flush with rst: rst wins.
- cond_true, combinational from flags_q:
  - 0: Z
  - 1: S^V
  - 2: Z|(S^V)
  - 3: ~Z
  - 4: 1
  - 5..7: 0
- Arithmetic: none; data passes unmodified. Widths are exact; no extension.

Optional Feature:
- Macro FLAG_BYPASS_EN.
- Defined: cond_true is evaluated on the next-state flags, i.e. the flags an accepted flag-setting entry will load this cycle. This lets CMP followed by a branch resolve without a bubble.
- Undefined: cond_true uses flags_q only, so there is one cycle of flag latency.
- flags_q itself is identical in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode constants OP_ADD..OP_MOV.
  - Branch condition constants COND_BE, COND_BLT, COND_BLE, COND_BNE, COND_ALWAYS.
  - Flag bit indices FLAG_S/Z/C/V.
  - Functions writes_reg(opcode) and flag_mask(opcode).
- One natural sub-module: wb_skid_buf, the generic 2-entry valid/ready skid buffer, parameterized by payload width.
- Flag register and condition logic stay in the top module.

Test Plan:
- Reset then idle:
  - Expect out_valid=0, flags_q=0000, in_ready=1.
  - With cond=4, cond_true=1; with cond=0, cond_true=0.
- ADD alu_out=0x0000 with z=1, c=1, rd=2, out_ready=1:
  - Next cycle out_valid=1, wb_we=1, wb_rd=2, wb_data=0x0000.
  - flags_q=0110 {S,Z,C,V}.
- CMP with s=1, v=0, then cond=1:
  - Expect wb_we=0 with out_valid=1.
  - cond_true=1 one cycle after acceptance; same cycle when FLAG_BYPASS_EN is defined.
- out_ready=0, three back-to-back valid entries 0x1111, 0x2222, 0x3333:
  - The first two are accepted; in_ready=0 blocks the third.
  - With out_ready=1, the output order is 0x1111, 0x2222, 0x3333 with no loss or duplication.
- XOR after SUB that set C=1, V=1: expect C=0, V=0; S and Z follow the XOR result.
- Both entries full, then flush=1 with in_valid=1:
  - Next cycle out_valid=0, in_ready=1.
  - flags_q unchanged; the flushed-cycle input is not observed.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute/write-back slice: opcode and branch
// condition encodings, flag bit positions and opcode decode helpers.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;

  localparam logic [2:0] COND_BE     = 3'd0;
  localparam logic [2:0] COND_BLT    = 3'd1;
  localparam logic [2:0] COND_BLE    = 3'd2;
  localparam logic [2:0] COND_BNE    = 3'd3;
  localparam logic [2:0] COND_ALWAYS = 3'd4;

  // Flag vector layout is {S,Z,C,V}.
  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Opcodes whose result is written to the register file.
  function automatic logic writes_reg(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: writes_reg = 1'b1;
      default:                                       writes_reg = 1'b0;
    endcase
  endfunction

  // Opcodes that update the condition codes at all.
  function automatic logic sets_flags(input logic [3:0] op);
    sets_flags = (op <= OP_MOV);
  endfunction

  // Which ALU flags are loaded; unmasked bits of a flag-setting opcode clear.
  function automatic logic [3:0] flag_mask(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_CMP:         flag_mask = 4'b1111;
      OP_AND, OP_OR, OP_XOR, OP_MOV:  flag_mask = 4'b1100;
      default:                        flag_mask = 4'b0000;
    endcase
  endfunction

  // Branch condition evaluation against a {S,Z,C,V} flag vector.
  function automatic logic cond_eval(input logic [2:0] sel, input logic [3:0] fl);
    case (sel)
      COND_BE:     cond_eval = fl[FLAG_Z];
      COND_BLT:    cond_eval = fl[FLAG_S] ^ fl[FLAG_V];
      COND_BLE:    cond_eval = fl[FLAG_Z] | (fl[FLAG_S] ^ fl[FLAG_V]);
      COND_BNE:    cond_eval = ~fl[FLAG_Z];
      COND_ALWAYS: cond_eval = 1'b1;
      default:     cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The head (main) entry drives the
// output; the skid entry catches one extra beat while the consumer stalls.
// in_ready is registered: it is simply the inverse of the skid occupancy.
module wb_skid_buf #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              accept_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  assign in_ready_o  = ~skid_valid_q;
  assign accept_o    = in_valid_i & ~skid_valid_q & ~flush_i;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

  // Next-state selection for the two buffer slots.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Full: nothing can be accepted; drain skid into main when consumed.
      if (out_ready_i) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept_o) begin
      if (main_valid_q && !out_ready_i) begin
        skid_data_d  = in_data_i;
        skid_valid_d = 1'b1;
      end else begin
        main_data_d  = in_data_i;
        main_valid_d = 1'b1;
      end
    end else if (main_valid_q && out_ready_i) begin
      main_valid_d = 1'b0;
    end
  end

  // Slot registers; data is also cleared so the idle output reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: buffers ALU results in a 2-entry skid buffer,
// drives register write-back, owns the {S,Z,C,V} condition codes and
// evaluates branch conditions.
// Optional build macro FLAG_BYPASS_EN: branch conditions see the flags being
// loaded this cycle instead of only the registered flags.
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_s,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic [3:0]        opcode,
  input  logic [REG_AW-1:0] rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_we,
  output logic [3:0]        flags_q,
  input  logic [2:0]        cond,
  output logic              cond_true
);

  localparam int PAY_W = 4 + REG_AW + DATA_W;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] head_pay;
  logic [3:0]       head_op;
  logic             accept;
  logic [3:0]       alu_flags;
  logic [3:0]       flags_d;

  assign in_pay    = {opcode, rd, alu_out};
  assign alu_flags = {alu_s, alu_z, alu_c, alu_v};

  wb_skid_buf #(
    .DATA_W (PAY_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_pay),
    .accept_o    (accept),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (head_pay)
  );

  assign wb_data = head_pay[DATA_W-1:0];
  assign wb_rd   = head_pay[DATA_W +: REG_AW];
  assign head_op = head_pay[DATA_W+REG_AW +: 4];
  assign wb_we   = out_valid & writes_reg(head_op);

  // Flags load at acceptance; unmasked bits of a flag-setting opcode clear.
  always_comb begin
    flags_d = flags_q;
    if (accept && sets_flags(opcode)) begin
      flags_d = alu_flags & flag_mask(opcode);
    end
  end

  // Architectural condition-code register.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

`ifdef FLAG_BYPASS_EN
  // Branch resolves on the flags being loaded this cycle.
  assign cond_true = cond_eval(cond, flags_d);
`else
  // Branch resolves on the registered flags only.
  assign cond_true = cond_eval(cond, flags_q);
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed, table-driven bench for alu_wb_stage with hand-written sequences
// for back-pressure, flush, reset and flag-bypass corner cases.
module tb_alu_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_out;
  logic        alu_s, alu_z, alu_c, alu_v;
  logic [3:0]  opcode;
  logic [2:0]  rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        wb_we;
  logic [3:0]  flags_q;
  logic [2:0]  cond;
  logic        cond_true;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_wb_stage #(.DATA_W(16), .REG_AW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_out   (alu_out),
    .alu_s     (alu_s),
    .alu_z     (alu_z),
    .alu_c     (alu_c),
    .alu_v     (alu_v),
    .opcode    (opcode),
    .rd        (rd),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wb_data   (wb_data),
    .wb_rd     (wb_rd),
    .wb_we     (wb_we),
    .flags_q   (flags_q),
    .cond      (cond),
    .cond_true (cond_true)
  );

  typedef struct {
    logic        iv;
    logic [3:0]  op;
    logic [15:0] d;
    logic [3:0]  f;     // ALU {S,Z,C,V}
    logic [2:0]  rdv;
    logic        ordy;
    logic [2:0]  cnd;
    logic        e_ov;
    logic        e_we;
    logic [2:0]  e_rd;
    logic [15:0] e_d;
    logic [3:0]  e_fl;
    logic        e_ct;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [3:0] op, input logic [15:0] d,
                       input logic [3:0] f, input logic [2:0] r);
    in_valid = iv;
    opcode   = op;
    alu_out  = d;
    {alu_s, alu_z, alu_c, alu_v} = f;
    rd       = r;
  endtask

  // One clock: inputs held across the edge, then one-shot controls dropped.
  task automatic cycle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    rst      = 1'b0;
    #1;
  endtask

  logic [15:0] got [$];
  logic        pending;
  logic        acc_now;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; cond = 3'd4;
    drive(1'b0, 4'd0, 16'h0, 4'h0, 3'd0);

    //        iv op  data      flags   rd  ordy cond ov we rd  data      flags   ct
    tbl[0]  = '{1, 0, 16'h0000, 4'b0110, 2, 1, 0, 1, 1, 2, 16'h0000, 4'b0110, 1};
    tbl[1]  = '{0, 0, 16'h0000, 4'b0000, 0, 1, 3, 0, 0, 0, 16'h0000, 4'b0110, 0};
    tbl[2]  = '{1, 1, 16'h8001, 4'b1011, 3, 1, 1, 1, 1, 3, 16'h8001, 4'b1011, 0};
    tbl[3]  = '{1, 4, 16'h0000, 4'b0111, 4, 1, 2, 1, 1, 4, 16'h0000, 4'b0100, 1};
    tbl[4]  = '{1, 5, 16'hFFFF, 4'b1000, 5, 1, 1, 1, 0, 5, 16'hFFFF, 4'b1000, 1};
    tbl[5]  = '{1, 7, 16'h1234, 4'b0111, 6, 1, 5, 1, 0, 6, 16'h1234, 4'b1000, 0};
    tbl[6]  = '{1, 15, 16'hABCD, 4'b0100, 2, 1, 0, 1, 0, 2, 16'hABCD, 4'b1000, 0};
    tbl[7]  = '{1, 6, 16'h7FFF, 4'b0011, 7, 1, 4, 1, 1, 7, 16'h7FFF, 4'b0000, 1};
    tbl[8]  = '{1, 2, 16'h0000, 4'b0100, 1, 1, 3, 1, 1, 1, 16'h0000, 4'b0100, 0};
    tbl[9]  = '{1, 3, 16'hF000, 4'b1000, 0, 1, 0, 1, 1, 0, 16'hF000, 4'b1000, 0};
    tbl[10] = '{0, 0, 16'h0000, 4'b0000, 0, 1, 6, 0, 0, 0, 16'h0000, 4'b1000, 0};
    tbl[11] = '{0, 0, 16'h0000, 4'b0000, 0, 1, 7, 0, 0, 0, 16'h0000, 4'b1000, 0};

    // Reset state.
    rst = 1'b1;
    @(posedge clk); #1;
    cycle();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_flags",     {28'd0, flags_q},   32'd0);
    chk("rst_wb_we",     {31'd0, wb_we},     32'd0);
    chk("rst_wb_data",   {16'd0, wb_data},   32'd0);
    chk("rst_wb_rd",     {29'd0, wb_rd},     32'd0);
    cond = 3'd4; #1;
    chk("rst_cond_always", {31'd0, cond_true}, 32'd1);
    cond = 3'd0; #1;
    chk("rst_cond_be", {31'd0, cond_true}, 32'd0);

    // Table-driven single-beat vectors.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].iv, tbl[i].op, tbl[i].d, tbl[i].f, tbl[i].rdv);
      out_ready = tbl[i].ordy;
      cond      = tbl[i].cnd;
      cycle();
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
      chk($sformatf("v%0d_wb_we", i),     {31'd0, wb_we},     {31'd0, tbl[i].e_we});
      chk($sformatf("v%0d_in_ready", i),  {31'd0, in_ready},  32'd1);
      chk($sformatf("v%0d_flags", i),     {28'd0, flags_q},   {28'd0, tbl[i].e_fl});
      chk($sformatf("v%0d_cond_true", i), {31'd0, cond_true}, {31'd0, tbl[i].e_ct});
      if (tbl[i].e_ov) begin
        chk($sformatf("v%0d_wb_rd", i),   {29'd0, wb_rd},   {29'd0, tbl[i].e_rd});
        chk($sformatf("v%0d_wb_data", i), {16'd0, wb_data}, {16'd0, tbl[i].e_d});
      end
    end

    // Back-pressure: two accepted, third blocked, then ordered drain.
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 16'h1111, 4'b0000, 3'd1);
    cycle();
    chk("bp1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp1_in_ready",  {31'd0, in_ready},  32'd1);
    chk("bp1_wb_data",   {16'd0, wb_data},   32'h1111);
    drive(1'b1, 4'd0, 16'h2222, 4'b0000, 3'd2);
    cycle();
    chk("bp2_in_ready",  {31'd0, in_ready},  32'd0);
    chk("bp2_wb_data",   {16'd0, wb_data},   32'h1111);
    drive(1'b1, 4'd0, 16'h3333, 4'b0000, 3'd3);
    cycle();
    chk("bp3_in_ready",  {31'd0, in_ready},  32'd0);
    chk("bp3_wb_data",   {16'd0, wb_data},   32'h1111);
    chk("bp3_wb_rd",     {29'd0, wb_rd},     32'd1);
    out_ready = 1'b1;
    pending = 1'b1;
    for (int c = 0; c < 8; c++) begin
      drive(pending, 4'd0, 16'h3333, 4'b0000, 3'd3);
      #1;
      if (out_valid) got.push_back(wb_data);
      acc_now = pending & in_ready;
      cycle();
      if (acc_now) pending = 1'b0;
    end
    chk("drain_count", got.size(), 32'd3);
    if (got.size() == 3) begin
      chk("drain_0", {16'd0, got[0]}, 32'h1111);
      chk("drain_1", {16'd0, got[1]}, 32'h2222);
      chk("drain_2", {16'd0, got[2]}, 32'h3333);
    end
    chk("drain_idle", {31'd0, out_valid}, 32'd0);

    // Flush with both entries full and an input presented.
    out_ready = 1'b0;
    drive(1'b1, 4'd1, 16'hAAAA, 4'b1011, 3'd1);
    cycle();
    chk("fl_sub_flags", {28'd0, flags_q}, 32'b1011);
    drive(1'b1, 4'd6, 16'hBBBB, 4'b1011, 3'd2);
    cycle();
    chk("fl_full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("fl_mov_flags",     {28'd0, flags_q},  32'b1000);
    drive(1'b1, 4'd0, 16'hCCCC, 4'b0110, 3'd3);
    flush = 1'b1;
    cycle();
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready",  {31'd0, in_ready},  32'd1);
    chk("fl_flags",     {28'd0, flags_q},   32'b1000);
    chk("fl_wb_we",     {31'd0, wb_we},     32'd0);
    drive(1'b1, 4'd0, 16'hCCCC, 4'b0110, 3'd3);
    flush = 1'b1;
    cycle();
    chk("fl2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl2_flags",     {28'd0, flags_q},   32'b1000);
    out_ready = 1'b1;
    cycle();
    chk("fl3_out_valid", {31'd0, out_valid}, 32'd0);

    // CMP then branch: flag latency vs bypass.
    out_ready = 1'b1;
    drive(1'b1, 4'd0, 16'h0005, 4'b0000, 3'd1);
    cycle();
    chk("cmp_pre_flags", {28'd0, flags_q}, 32'd0);
    drive(1'b1, 4'd5, 16'hFFFE, 4'b1000, 3'd4);
    cond = 3'd1;
    #1;
`ifdef FLAG_BYPASS_EN
    chk("cmp_same_cycle_cond", {31'd0, cond_true}, 32'd1);
`else
    chk("cmp_same_cycle_cond", {31'd0, cond_true}, 32'd0);
`endif
    cycle();
    chk("cmp_cond_true", {31'd0, cond_true}, 32'd1);
    chk("cmp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("cmp_wb_we",     {31'd0, wb_we},     32'd0);
    chk("cmp_flags",     {28'd0, flags_q},   32'b1000);

    // Reset mid-transfer, with flush and an input also asserted.
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 16'h5555, 4'b0110, 3'd5);
    cycle();
    drive(1'b1, 4'd0, 16'h6666, 4'b0110, 3'd6);
    cycle();
    chk("mr_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 4'd0, 16'h7777, 4'b1111, 3'd7);
    rst = 1'b1;
    flush = 1'b1;
    cycle();
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_in_ready2", {31'd0, in_ready},  32'd1);
    chk("mr_flags",     {28'd0, flags_q},   32'd0);
    chk("mr_wb_data",   {16'd0, wb_data},   32'd0);
    chk("mr_wb_rd",     {29'd0, wb_rd},     32'd0);
    chk("mr_wb_we",     {31'd0, wb_we},     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
